// File: rtl/bram_ctrl_pkg.sv
// Shared definitions for the block-RAM burst controller and the RAM array it drives.
// Holds the controller state encoding, the data/block geometry and the address-width helper.
package bram_ctrl_pkg;

    localparam int DATA_W      = 16;
    localparam int BLOCK_DEPTH = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Word-address width of an array of num_blocks blocks of BLOCK_DEPTH words.
    function automatic int calc_addr_w(input int num_blocks);
        return $clog2(BLOCK_DEPTH) + $clog2(num_blocks);
    endfunction

endpackage

// File: rtl/bram_burst_ctrl_rd_skid.sv
// Two-entry read-data FIFO that absorbs the RAM's one-cycle read latency.
// The head is driven from storage registers; nothing bypasses from push to head.
module bram_rd_skid
    import bram_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        count,
    output logic              empty
);

    logic [DATA_W-1:0] mem_r [2];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        count_r;
    logic              pop_ok_s;
    logic              push_ok_s;

    // A full FIFO only takes a push when it is also being popped.
    assign pop_ok_s  = pop && (count_r != 2'd0);
    assign push_ok_s = push && ((count_r != 2'd2) || pop_ok_s);

    // Storage, pointers and occupancy; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_r[0] <= {DATA_W{1'b0}};
            mem_r[1] <= {DATA_W{1'b0}};
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == 2'd0);

endmodule

// File: rtl/bram_burst_ctrl.sv
// Burst initiator for the banked 16-bit block-RAM array: one command at a time,
// streaming write beats in or read beats out under valid/ready flow control.
module bram_burst_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter  int NUM_BLOCKS = 16,
    localparam int ADDR_W     = calc_addr_w(NUM_BLOCKS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_r;
    state_e            state_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_nxt_s;
    logic [ADDR_W-1:0] remain_r;
    logic [ADDR_W-1:0] remain_nxt_s;
    logic              inflight_r;
    logic              done_r;
    logic              done_nxt_s;
    logic              issue_s;
    logic              pop_s;
    logic              wr_fire_s;
    logic [1:0]        fifo_cnt_s;
    logic              fifo_empty_s;
    logic [2:0]        occ_s;

    // Occupancy counts the read already in flight and credits a beat leaving this cycle.
    assign pop_s     = ~fifo_empty_s & rd_ready;
    assign occ_s     = {1'b0, fifo_cnt_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign issue_s   = (state_r == ST_READ) && (occ_s < 3'd2);
    assign wr_fire_s = (state_r == ST_WRITE) && wr_valid;

    bram_rd_skid u_rd_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_r),
        .pop   (pop_s),
        .din   (mem_rdata),
        .dout  (rd_data),
        .count (fifo_cnt_s),
        .empty (fifo_empty_s)
    );

    // Next-state, address/count updates and completion pulse.
    always_comb begin
        state_nxt_s  = state_r;
        addr_nxt_s   = addr_r;
        remain_nxt_s = remain_r;
        done_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_nxt_s   = cmd_addr;
                    remain_nxt_s = cmd_len;
                    state_nxt_s  = cmd_write ? ST_WRITE : ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (wr_fire_s) begin
                    addr_nxt_s   = addr_r + ADDR_ONE;
                    remain_nxt_s = remain_r - ADDR_ONE;
                    if (remain_r == ADDR_ZERO) begin
                        state_nxt_s = ST_IDLE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_WRITE;
                    end
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_READ: begin
                if (issue_s) begin
                    addr_nxt_s   = addr_r + ADDR_ONE;
                    remain_nxt_s = remain_r - ADDR_ONE;
                    if (remain_r == ADDR_ZERO) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_READ;
                    end
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                // Finish as the last beat leaves, so done lands the cycle after it is taken.
                if (!inflight_r && (fifo_cnt_s == {1'b0, pop_s})) begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Controller registers; reset abandons any burst and drops in-flight read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            addr_r     <= ADDR_ZERO;
            remain_r   <= ADDR_ZERO;
            inflight_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            addr_r     <= addr_nxt_s;
            remain_r   <= remain_nxt_s;
            inflight_r <= issue_s;
            done_r     <= done_nxt_s;
        end
    end

    assign cmd_ready   = rst_n & (state_r == ST_IDLE);
    assign wr_ready    = (state_r == ST_WRITE);
    assign busy        = (state_r != ST_IDLE);
    assign done        = done_r;
    assign rd_valid    = ~fifo_empty_s;
    assign mem_rd_en   = issue_s;
    assign mem_rd_addr = addr_r;
    assign mem_wr_en   = wr_fire_s;
    assign mem_wr_addr = addr_r;
    assign mem_wdata   = wr_data;

endmodule

// File: tb/tb_bram_burst_ctrl.sv
// Directed bench for bram_burst_ctrl with a behavioural 4096x16 RAM behind it.
module tb_bram_burst_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [11:0] cmd_len;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [11:0] mem_rd_addr;
    logic        mem_wr_en;
    logic [11:0] mem_wr_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int cyc       = 0;

    int          acc_q [$];
    int          done_q [$];
    logic [15:0] rd_q [$];
    int          rdc_q [$];
    logic [11:0] wa_q [$];
    logic [15:0] wd_q [$];
    int          rden_n;
    int          iss_n;
    int          pop_n;

    logic [15:0] ram [0:4095];

    bram_burst_ctrl #(.NUM_BLOCKS(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: write port, and read data one cycle after the read enable.
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_wr_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= ram[mem_rd_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Event log and issue-room checks, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            iss_n = 0;
            pop_n = 0;
        end else begin
            int pop_now;
            pop_now = (rd_valid && rd_ready) ? 1 : 0;
            check_val("rd_wr_exclusive", {31'd0, mem_rd_en & mem_wr_en}, 32'd0);
            check_val("buf_le_2", ((iss_n - pop_n) <= 2) ? 32'd1 : 32'd0, 32'd1);
            if (mem_rd_en) begin
                check_val("issue_room", ((iss_n - pop_n - pop_now) < 2) ? 32'd1 : 32'd0, 32'd1);
                rden_n++;
                iss_n++;
            end
            if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
            if (mem_wr_en) begin
                wa_q.push_back(mem_wr_addr);
                wd_q.push_back(mem_wdata);
            end
            if (pop_now == 1) begin
                rd_q.push_back(rd_data);
                rdc_q.push_back(cyc);
                pop_n++;
            end
            if (done) done_q.push_back(cyc);
        end
    end

    task automatic clear_logs();
        acc_q.delete();
        done_q.delete();
        rd_q.delete();
        rdc_q.delete();
        wa_q.delete();
        wd_q.delete();
        rden_n = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer a command until it is taken (bounded); returns one cycle after acceptance.
    task automatic send_cmd(input logic w, input logic [11:0] a, input logic [11:0] l);
        logic got;
        got       = 1'b0;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
            #1;
            got = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        check_val("cmd_accept", {31'd0, got}, 32'd1);
    endtask

    task automatic write_beats(input logic [15:0] first, input int n);
        wr_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            wr_data = first + 16'(i);
            #1;
            check_val("wr_ready", {31'd0, wr_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        logic [11:0] exp_wa [4];
        logic [15:0] pat;
        exp_wa = '{12'h0FE, 12'h0FF, 12'h100, 12'h101};
        pat    = 16'b0010_1101_1001_0100;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 12'h000;
        cmd_len = 12'h000; wr_data = 16'h0000; wr_valid = 1'b0; rd_ready = 1'b0;
        clear_logs();
        for (int i = 0; i < 2; i++) begin
            tick(1);
            check_val("rst_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        end
        rst_n = 1'b1;
        #1;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_en", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
        check_val("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Write burst crossing a block boundary.
        clear_logs();
        send_cmd(1'b1, 12'h0FE, 12'h003);
        write_beats(16'hA001, 4);
        tick(3);
        check_val("w1_writes", wa_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_val("w1_addr", {20'd0, wa_q[i]}, {20'd0, exp_wa[i]});
            check_val("w1_data", {16'd0, wd_q[i]}, {16'd0, 16'hA001 + 16'(i)});
        end
        check_val("w1_done_cnt", done_q.size(), 1);
        check_val("w1_done_cyc", done_q[0] - acc_q[0], 5);

        // Read back with rd_ready held high: latency and throughput.
        clear_logs();
        rd_ready = 1'b1;
        send_cmd(1'b0, 12'h0FE, 12'h003);
        tick(10);
        check_val("r1_beats", rd_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_val("r1_data", {16'd0, rd_q[i]}, {16'd0, 16'hA001 + 16'(i)});
            check_val("r1_cyc", rdc_q[i] - acc_q[0], 3 + i);
        end
        check_val("r1_done_cnt", done_q.size(), 1);
        check_val("r1_done_cyc", done_q[0] - acc_q[0], 7);
        check_val("r1_rden", rden_n, 4);

        // Same read under irregular backpressure.
        clear_logs();
        rd_ready = 1'b0;
        send_cmd(1'b0, 12'h0FE, 12'h003);
        for (int i = 0; i < 40; i++) begin
            rd_ready = pat[i % 16];
            tick(1);
        end
        rd_ready = 1'b1;
        tick(5);
        check_val("r2_beats", rd_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_val("r2_data", {16'd0, rd_q[i]}, {16'd0, 16'hA001 + 16'(i)});
        end
        check_val("r2_done_cnt", done_q.size(), 1);
        check_val("r2_rden", rden_n, 4);

        // Address wrap from the top of the array to zero.
        clear_logs();
        send_cmd(1'b1, 12'hFFF, 12'h001);
        wr_valid = 1'b1;
        wr_data  = 16'h1111;
        tick(1);
        wr_data  = 16'h2222;
        tick(1);
        wr_valid = 1'b0;
        tick(2);
        check_val("wrap_writes", wa_q.size(), 2);
        check_val("wrap_addr0", {20'd0, wa_q[0]}, 32'h0000_0FFF);
        check_val("wrap_addr1", {20'd0, wa_q[1]}, 32'h0000_0000);
        clear_logs();
        send_cmd(1'b0, 12'hFFF, 12'h001);
        tick(8);
        check_val("wrap_beats", rd_q.size(), 2);
        check_val("wrap_rd0", {16'd0, rd_q[0]}, 32'h0000_1111);
        check_val("wrap_rd1", {16'd0, rd_q[1]}, 32'h0000_2222);

        // Single-word write, then single-word read with a command held pending.
        clear_logs();
        send_cmd(1'b1, 12'h055, 12'h000);
        write_beats(16'hBEEF, 1);
        tick(2);
        check_val("s_writes", wa_q.size(), 1);
        check_val("s_wdone", done_q.size(), 1);
        clear_logs();
        send_cmd(1'b0, 12'h055, 12'h000);
        cmd_valid = 1'b1;
        for (int n = 0; n < 20 && acc_q.size() < 2; n++) tick(1);
        cmd_valid = 1'b0;
        tick(8);
        check_val("s_accepts", acc_q.size(), 2);
        check_val("s_done_cnt", done_q.size(), 2);
        check_val("s_done_cyc", done_q[0] - acc_q[0], 4);
        check_val("s_hold_not_early", (acc_q[1] >= done_q[0]) ? 32'd1 : 32'd0, 32'd1);
        check_val("s_rden", rden_n, 2);
        check_val("s_beats", rd_q.size(), 2);
        check_val("s_rd0", {16'd0, rd_q[0]}, 32'h0000_BEEF);
        check_val("s_rd1", {16'd0, rd_q[1]}, 32'h0000_BEEF);

        // Reset in the middle of an 8-word read.
        clear_logs();
        rd_ready = 1'b1;
        send_cmd(1'b0, 12'h0FE, 12'h007);
        tick(3);
        rd_ready = 1'b0;
        tick(3);
        rst_n = 1'b0;
        #1;
        check_val("mr_cmd_ready_in_rst", {31'd0, cmd_ready}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        #1;
        check_val("mr_rd_valid", {31'd0, rd_valid}, 32'd0);
        check_val("mr_busy", {31'd0, busy}, 32'd0);
        check_val("mr_done", {31'd0, done}, 32'd0);
        check_val("mr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        tick(2);
        check_val("mr_no_stale", {31'd0, rd_valid}, 32'd0);
        check_val("mr_beats", rd_q.size(), 1);
        check_val("mr_rd0", {16'd0, rd_q[0]}, 32'h0000_A001);
        check_val("mr_no_done", done_q.size(), 0);
        clear_logs();
        rd_ready = 1'b1;
        send_cmd(1'b0, 12'h0FE, 12'h000);
        tick(6);
        check_val("mr_new_beats", rd_q.size(), 1);
        check_val("mr_new_rd", {16'd0, rd_q[0]}, 32'h0000_A001);
        check_val("mr_new_done", done_q.size(), 1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/bram_burst_ctrl.md
Name: bram_burst_ctrl

Overview:
Initiator-side controller for the banked 16-bit block-RAM array. It accepts one burst command at a time (read or write, base address, length) on a valid/ready handshake and streams write data in or read data out with valid/ready flow control. It drives the RAM's separate read and write ports and absorbs the RAM's one-cycle read latency with a 2-entry output buffer, so the read stream tolerates arbitrary backpressure. It sits between a host command path (e.g. a UART/SPI command decoder) and the RAM array.

Parameters:
NUM_BLOCKS, 16, number of 256x16 RAM blocks; power of two, >=1
ADDR_W, 8+$clog2(NUM_BLOCKS), word address width (localparam)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  controller idle; command accepted when cmd_valid&cmd_ready
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_W  burst start word address
cmd_len  in  ADDR_W  burst length minus one (0 means 1 word, all-ones means 2^ADDR_W words)
wr_data  in  16  write beat data
wr_valid  in  1  write beat offered
wr_ready  out  1  write beat accepted when wr_valid&wr_ready
rd_data  out  16  read beat data
rd_valid  out  1  read beat available
rd_ready  in  1  consumer takes beat when rd_valid&rd_ready
busy  out  1  not IDLE
done  out  1  one-cycle pulse when a burst completes
mem_rd_en  out  1  RAM read enable
mem_rd_addr  out  ADDR_W  RAM read address
mem_wr_en  out  1  RAM write enable
mem_wr_addr  out  ADDR_W  RAM write address
mem_wdata  out  16  RAM write data
mem_rdata  in  16  RAM read data, valid the cycle after mem_rd_en

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, counters=0, buffer flushed, in-flight flag cleared; done=0, rd_valid=0, busy=0, mem_rd_en=0, mem_wr_en=0. cmd_ready=0 while rst_n is low. Reset mid-burst abandons the burst silently, with no done pulse. Any in-flight mem_rdata is discarded.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: cmd_ready=1. On accept, latch addr and remaining count (cmd_len), then go to WRITE or READ. cmd_valid in other states is ignored (cmd_ready=0).
- WRITE: wr_ready=1.
  - mem_wr_en = wr_valid (combinational).
  - mem_wr_addr = addr counter; mem_wdata = wr_data.
  - Each accepted beat increments addr and decrements remaining.
  - The beat accepted with remaining==0 returns to IDLE; done=1 in the following cycle.
- READ: issue mem_rd_en when buffer_count + inflight - pop_this_cycle < 2.
  - mem_rd_addr = addr counter.
  - Each issue increments addr and decrements remaining. The issue with remaining==0 moves to DRAIN.
  - inflight is set on issue and cleared next cycle. mem_rdata is pushed into the buffer in the cycle after issue.
- DRAIN: no issues. When the buffer is empty and inflight=0, return to IDLE; done=1 in the following cycle.
- Buffer: 2-entry FIFO. rd_valid = not empty; rd_data = head (registered, no bypass).
  - Push and pop in the same cycle are allowed.
  - The issue rule guarantees no overflow.
- Read latency with rd_ready held high:
  - cmd accept at cycle 0, first mem_rd_en at cycle 1, first rd_valid at cycle 3.
  - Then one beat per cycle. done is asserted the cycle after the last beat is taken.
- Address arithmetic is modulo 2^ADDR_W: bursts wrap from the top address to 0. Block crossings are transparent.
- mem_rd_en and mem_wr_en are never both 1 in the same cycle.
- busy = (state != IDLE).

Decomposition:
- Shared package bram_ctrl_pkg: state encoding constants (IDLE/WRITE/READ/DRAIN), DATA_W=16, BLOCK_DEPTH=256, and an addr-width function of NUM_BLOCKS shared with the RAM array.
- One sub-module: bram_rd_skid, the 2-entry 16-bit FIFO with count, push/pop, and flush on reset.

Test Plan:
- Write, NUM_BLOCKS=16: cmd_addr=0x0FE, cmd_len=3, wr_valid held high, data 0xA001..0xA004 -> mem_wr_en for 4 cycles at addrs 0x0FE, 0x0FF, 0x100, 0x101; done one cycle after the 4th beat.
- Read back the same burst with rd_ready=1 -> rd_valid at cycles 3..6 after accept, data 0xA001..0xA004 in order; done at cycle 7.
- Same read with rd_ready toggled pseudo-randomly -> same 4 words in order, no loss or duplication, buffer never exceeds 2 entries, no mem_rd_en while buffer+inflight=2.
- Wrap: cmd_addr=0xFFF, cmd_len=1, write 0x1111, 0x2222 -> writes land at 0xFFF then 0x000; readback matches.
- Single word: cmd_len=0 read at 0x055 -> exactly one mem_rd_en and one rd_valid beat; done pulses once. A cmd_valid held during the burst is not accepted until done has been seen.
- Reset mid-read: deassert rd_ready after 1 of 8 beats, pull rst_n low for 1 cycle -> next cycle rd_valid=0, busy=0, done=0, cmd_ready=1; a new command is accepted normally.
